// File: rtl/cmda_dly_seq.sv
// cmda_dly_seq: delay-programming sequencer for the DDR3 command/address PHY lanes.
// Takes delay-write requests over valid/ready and drives one-hot ld strobes, a shared
// delay bus and a guarded set pulse into the per-lane output delay cells.
// Optional shadow readback is compiled in with `define CMDA_DLY_READBACK_EN.
module cmda_dly_seq #(
    parameter int unsigned ADDRESS_NUMBER = 15,
    parameter int unsigned CMD_LINES      = 8,
    parameter int unsigned DLY_WIDTH      = 8,
    parameter int unsigned SET_GAP        = 2
) (
    input  logic                      clk_div,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [4:0]                req_addr,
    input  logic [4:0]                req_len,
    input  logic [DLY_WIDTH-1:0]      req_data,
    input  logic                      req_bcast,
    input  logic                      req_commit,
    output logic [DLY_WIDTH-1:0]      dly_data,
    output logic [ADDRESS_NUMBER-1:0] ld_addr,
    output logic [CMD_LINES-1:0]      ld_cmd,
    output logic                      set,
    output logic                      busy,
    output logic                      err,
    input  logic                      err_clr,
    input  logic [4:0]                rd_addr,
    output logic [DLY_WIDTH-1:0]      rd_data
);

    localparam int unsigned CMD_BASE = 24;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BCAST, S_GAP, S_SET} state_t;

    state_t                    state_q, state_d;
    logic [4:0]                cur_q, cur_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [DLY_WIDTH-1:0]      data_q, data_d;
    logic                      commit_q, commit_d;
    logic [3:0]                gap_q, gap_d;
    logic [DLY_WIDTH-1:0]      dly_data_q, dly_data_d;
    logic [ADDRESS_NUMBER-1:0] ld_addr_q, ld_addr_d;
    logic [CMD_LINES-1:0]      ld_cmd_q, ld_cmd_d;
    logic                      set_q, set_d;
    logic                      busy_q, busy_d;
    logic                      err_q, err_d;

    function automatic logic lane_valid(input logic [4:0] n);
        lane_valid = ({1'b0, n} < 6'(ADDRESS_NUMBER)) ||
                     (({1'b0, n} >= 6'(CMD_BASE)) && ({1'b0, n} < 6'(CMD_BASE + CMD_LINES)));
    endfunction

    assign req_ready = (state_q == S_IDLE);
    assign dly_data  = dly_data_q;
    assign ld_addr   = ld_addr_q;
    assign ld_cmd    = ld_cmd_q;
    assign set       = set_q;
    assign busy      = busy_q;
    assign err       = err_q;

    // State and registered outputs.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            commit_q   <= 1'b0;
            gap_q      <= '0;
            dly_data_q <= '0;
            ld_addr_q  <= '0;
            ld_cmd_q   <= '0;
            set_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            commit_q   <= commit_d;
            gap_q      <= gap_d;
            dly_data_q <= dly_data_d;
            ld_addr_q  <= ld_addr_d;
            ld_cmd_q   <= ld_cmd_d;
            set_q      <= set_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Next state: request latch, burst walk and gap countdown.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        commit_d = commit_q;
        gap_d    = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    data_d   = req_data;
                    commit_d = req_commit;
                    cur_d    = req_addr;
                    cnt_d    = req_len;
                    state_d  = req_bcast ? S_BCAST : S_LOAD;
                end
            end
            S_LOAD: begin
                cur_d = cur_q + 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = commit_q ? S_GAP : S_IDLE;
                    gap_d   = 4'(SET_GAP - 1);
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_BCAST: begin
                state_d = commit_q ? S_GAP : S_IDLE;
                gap_d   = 4'(SET_GAP - 1);
            end
            S_GAP: begin
                if (gap_q == 4'd0) state_d = S_SET;
                else               gap_d   = gap_q - 4'd1;
            end
            S_SET:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the next state so strobes line up with the state they belong to.
    always_comb begin
        ld_addr_d  = '0;
        ld_cmd_d   = '0;
        dly_data_d = dly_data_q;
        set_d      = (state_d == S_SET);
        busy_d     = (state_d != S_IDLE);
        err_d      = err_q & ~err_clr;
        if ((state_d == S_LOAD) || (state_d == S_BCAST)) dly_data_d = data_d;
        for (int i = 0; i < int'(ADDRESS_NUMBER); i++) begin
            ld_addr_d[i] = (state_d == S_BCAST) || ((state_d == S_LOAD) && (cur_d == 5'(i)));
        end
        for (int j = 0; j < int'(CMD_LINES); j++) begin
            ld_cmd_d[j] = (state_d == S_BCAST) ||
                          ((state_d == S_LOAD) && (cur_d == 5'(int'(CMD_BASE) + j)));
        end
        // A wasted cycle on an unmapped lane flags the error; set wins over clear.
        if ((state_q == S_LOAD) && !lane_valid(cur_q)) err_d = 1'b1;
    end

`ifdef CMDA_DLY_READBACK_EN
    localparam int unsigned NUM_ENTRIES = ADDRESS_NUMBER + CMD_LINES;

    logic [DLY_WIDTH-1:0] shadow_q [NUM_ENTRIES];
    logic [DLY_WIDTH-1:0] shadow_d [NUM_ENTRIES];
    logic [DLY_WIDTH-1:0] rd_data_q, rd_data_d;

    assign rd_data = rd_data_q;

    // Shadow file and readback register.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) shadow_q[i] <= '0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) shadow_q[i] <= shadow_d[i];
            rd_data_q <= rd_data_d;
        end
    end

    // Mirror every issued ld into the shadow; read the pre-write contents.
    always_comb begin
        for (int i = 0; i < int'(NUM_ENTRIES); i++) shadow_d[i] = shadow_q[i];
        rd_data_d = '0;
        for (int i = 0; i < int'(ADDRESS_NUMBER); i++) begin
            if (ld_addr_q[i]) shadow_d[i] = dly_data_q;
            if (rd_addr == 5'(i)) rd_data_d = shadow_q[i];
        end
        for (int j = 0; j < int'(CMD_LINES); j++) begin
            if (ld_cmd_q[j]) shadow_d[int'(ADDRESS_NUMBER) + j] = dly_data_q;
            if (rd_addr == 5'(int'(CMD_BASE) + j)) rd_data_d = shadow_q[int'(ADDRESS_NUMBER) + j];
        end
    end
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_cmda_dly_seq.sv
// Directed bench for cmda_dly_seq with default parameters (15 address, 8 command lanes, SET_GAP=2).
module tb_cmda_dly_seq;

    logic        clk_div = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [4:0]  req_len;
    logic [7:0]  req_data;
    logic        req_bcast;
    logic        req_commit;
    logic [7:0]  dly_data;
    logic [14:0] ld_addr;
    logic [7:0]  ld_cmd;
    logic        set;
    logic        busy;
    logic        err;
    logic        err_clr;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  rb_exp;

    cmda_dly_seq dut (
        .clk_div   (clk_div),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_bcast (req_bcast),
        .req_commit(req_commit),
        .dly_data  (dly_data),
        .ld_addr   (ld_addr),
        .ld_cmd    (ld_cmd),
        .set       (set),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk_div = ~clk_div;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk_div);
        @(negedge clk_div);
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] l, input logic [7:0] d,
                         input logic b, input logic c);
        req_valid  = 1'b1;
        req_addr   = a;
        req_len    = l;
        req_data   = d;
        req_bcast  = b;
        req_commit = c;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_data = '0;
        req_bcast = 1'b0; req_commit = 1'b0; err_clr = 1'b0; rd_addr = '0;
`ifdef CMDA_DLY_READBACK_EN
        rb_exp = 8'h21;
`else
        rb_exp = 8'h00;
`endif
        tick();
        chk("rst_ld_addr", 32'(ld_addr), 32'h0);
        chk("rst_ld_cmd", 32'(ld_cmd), 32'h0);
        chk("rst_set", 32'(set), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dly", 32'(dly_data), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // Single write, lane 3, no commit.
        issue(5'd3, 5'd0, 8'h5A, 1'b0, 1'b0);
        tick(); req_valid = 1'b0;
        chk("t1_c1_ld_addr", 32'(ld_addr), 32'h0008);
        chk("t1_c1_ld_cmd", 32'(ld_cmd), 32'h0);
        chk("t1_c1_dly", 32'(dly_data), 32'h5A);
        chk("t1_c1_ready", 32'(req_ready), 32'h0);
        chk("t1_c1_busy", 32'(busy), 32'h1);
        tick();
        chk("t1_c2_ld_addr", 32'(ld_addr), 32'h0);
        chk("t1_c2_ready", 32'(req_ready), 32'h1);
        chk("t1_c2_set", 32'(set), 32'h0);
        chk("t1_c2_dly_hold", 32'(dly_data), 32'h5A);

        // Wrap burst 30,31,0,1 with commit.
        issue(5'd30, 5'd3, 8'h3C, 1'b0, 1'b1);
        tick(); req_valid = 1'b0;
        chk("t2_c1_ld_cmd", 32'(ld_cmd), 32'h40);
        chk("t2_c1_ld_addr", 32'(ld_addr), 32'h0);
        tick();
        chk("t2_c2_ld_cmd", 32'(ld_cmd), 32'h80);
        tick();
        chk("t2_c3_ld_addr", 32'(ld_addr), 32'h0001);
        chk("t2_c3_ld_cmd", 32'(ld_cmd), 32'h0);
        tick();
        chk("t2_c4_ld_addr", 32'(ld_addr), 32'h0002);
        tick();
        chk("t2_c5_ld", 32'({ld_addr, ld_cmd}), 32'h0);
        chk("t2_c5_set", 32'(set), 32'h0);
        tick();
        chk("t2_c6_set", 32'(set), 32'h0);
        chk("t2_c6_busy", 32'(busy), 32'h1);
        tick();
        chk("t2_c7_set", 32'(set), 32'h1);
        chk("t2_c7_ready", 32'(req_ready), 32'h0);
        tick();
        chk("t2_c8_set", 32'(set), 32'h0);
        chk("t2_c8_ready", 32'(req_ready), 32'h1);
        chk("t2_err", 32'(err), 32'h0);
        chk("t2_dly_hold", 32'(dly_data), 32'h3C);

        // Invalid lanes 15 and 16 after lane 14; err_clr colliding with a new error.
        issue(5'd14, 5'd2, 8'h07, 1'b0, 1'b0);
        tick(); req_valid = 1'b0;
        chk("t3_c1_ld_addr", 32'(ld_addr), 32'h4000);
        chk("t3_c1_err", 32'(err), 32'h0);
        tick();
        chk("t3_c2_ld", 32'({ld_addr, ld_cmd}), 32'h0);
        chk("t3_c2_err", 32'(err), 32'h0);
        tick();
        chk("t3_c3_ld", 32'({ld_addr, ld_cmd}), 32'h0);
        chk("t3_c3_err", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        chk("t3_c4_err_set_wins", 32'(err), 32'h1);
        chk("t3_c4_ready", 32'(req_ready), 32'h1);
        tick();
        chk("t3_c5_err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        chk("t3_err_cleared", 32'(err), 32'h0);

        // Broadcast with commit.
        issue(5'd9, 5'd4, 8'h21, 1'b1, 1'b1);
        tick(); req_valid = 1'b0;
        chk("t4_c1_ld_addr", 32'(ld_addr), 32'h7FFF);
        chk("t4_c1_ld_cmd", 32'(ld_cmd), 32'hFF);
        chk("t4_c1_dly", 32'(dly_data), 32'h21);
        tick();
        chk("t4_c2_ld", 32'({ld_addr, ld_cmd}), 32'h0);
        tick();
        chk("t4_c3_set", 32'(set), 32'h0);
        tick();
        chk("t4_c4_set", 32'(set), 32'h1);
        tick();
        chk("t4_c5_set", 32'(set), 32'h0);
        chk("t4_c5_ready", 32'(req_ready), 32'h1);
        chk("t4_err", 32'(err), 32'h0);
        rd_addr = 5'd0;
        tick();
        chk("t4_rd_lane0", 32'(rd_data), 32'(rb_exp));
        rd_addr = 5'd31;
        tick();
        chk("t4_rd_lane31", 32'(rd_data), 32'(rb_exp));
        rd_addr = 5'd20;
        tick();
        chk("t4_rd_invalid", 32'(rd_data), 32'h0);
        rd_addr = 5'd31;

        // Asynchronous reset in the middle of a committed burst.
        issue(5'd0, 5'd7, 8'h77, 1'b0, 1'b1);
        tick(); req_valid = 1'b0;
        chk("t5_c1_ld_addr", 32'(ld_addr), 32'h0001);
        tick();
        chk("t5_c2_ld_addr", 32'(ld_addr), 32'h0002);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_ld", 32'({ld_addr, ld_cmd}), 32'h0);
        chk("t5_rst_dly", 32'(dly_data), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_ready", 32'(req_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_post_ready", 32'(req_ready), 32'h1);
        chk("t5_post_rd", 32'(rd_data), 32'h0);
        for (int k = 0; k < 14; k++) begin
            chk("t5_no_set", 32'({set, busy}), 32'h0);
            tick();
        end

        // Backpressure: second request waits for IDLE and carries its own data.
        issue(5'd5, 5'd1, 8'h11, 1'b0, 1'b0);
        tick();
        issue(5'd10, 5'd0, 8'h99, 1'b0, 1'b0);
        chk("t6_c1_ld_addr", 32'(ld_addr), 32'h0020);
        chk("t6_c1_dly", 32'(dly_data), 32'h11);
        chk("t6_c1_ready", 32'(req_ready), 32'h0);
        tick();
        chk("t6_c2_ld_addr", 32'(ld_addr), 32'h0040);
        chk("t6_c2_dly", 32'(dly_data), 32'h11);
        tick();
        chk("t6_c3_ready", 32'(req_ready), 32'h1);
        chk("t6_c3_ld", 32'({ld_addr, ld_cmd}), 32'h0);
        chk("t6_c3_dly", 32'(dly_data), 32'h11);
        tick(); req_valid = 1'b0;
        chk("t6_c4_ld_addr", 32'(ld_addr), 32'h0400);
        chk("t6_c4_dly", 32'(dly_data), 32'h99);
        tick();
        chk("t6_c5_ready", 32'(req_ready), 32'h1);
        chk("t6_c5_ld", 32'({ld_addr, ld_cmd}), 32'h0);
        chk("t6_c5_set", 32'(set), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
